// File: rtl/steer_en_pkg.sv
`default_nettype none
// ============================================================================
// Module  : steer_en_pkg
// Purpose : Shared types and constants for the steer-enable block: the
//           controller state encoding, default rider-weight thresholds and
//           the two settle-timer widths (simulation / silicon).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package steer_en_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  localparam logic [11:0] MIN_RIDER_WT_DFLT  = 12'h200;
  localparam logic [11:0] WT_HYSTERESIS_DFLT = 12'h040;

  // Settle timer widths: short one keeps simulations tractable.
  localparam int TMR_W_FAST = 15;
  localparam int TMR_W_FULL = 26;

endpackage
`default_nettype wire

// File: rtl/steer_tmr.sv
`default_nettype none
// ============================================================================
// Module  : steer_tmr
// Purpose : Saturating up-counter used as the rider settle timer.
// Ports   : clk  - system clock
//           rst  - synchronous active-high reset (count -> 0)
//           clr  - synchronous clear (count -> 0), wins over inc
//           inc  - advance count by one unless already full
//           full - count is all ones
// Rev     : 1.0  initial release
// ============================================================================
module steer_tmr #(
  parameter int WIDTH = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic full
);

  logic [WIDTH-1:0] r_count;

  assign full = &r_count;

  // Holds at all ones rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/steer_en.sv
`default_nettype none
// ============================================================================
// Module  : steer_en
// Purpose : Decides when steering may be enabled from the left/right load
//           cells: detects a rider with hysteresis, requires the load to be
//           balanced for a full settle-timer period, and drops back on
//           step-off imbalance or rider departure.
// Ports   : clk       - system clock
//           rst       - synchronous active-high reset
//           lft_ld    - left load-cell sample (unsigned, 12 bit)
//           rght_ld   - right load-cell sample (unsigned, 12 bit)
//           en_steer  - steering enabled (state STEER)
//           rider_off - no rider detected (state IDLE)
// Rev     : 1.0  initial release
// ============================================================================
module steer_en
  import steer_en_pkg::*;
#(
  parameter bit          FAST_SIM      = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DFLT,
  parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  localparam int          TMR_W    = FAST_SIM ? TMR_W_FAST : TMR_W_FULL;
  localparam logic [11:0] LEAVE_WT = MIN_RIDER_WT - WT_HYSTERESIS;

  state_t r_state;
  state_t w_next;

  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic [16:0] w_diff_x16;
  logic [16:0] w_sum_x15;
  logic        w_on_wt;
  logic        w_off_wt;
  logic        w_diff_small;
  logic        w_diff_big;
  logic        w_tmr_clr;
  logic        w_tmr_inc;
  logic        w_tmr_full;

  // --------------------------------------------------------------------------
  // Threshold arithmetic
  // --------------------------------------------------------------------------
  assign w_sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign w_diff = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);

  assign w_on_wt      = w_sum > {1'b0, MIN_RIDER_WT};
  assign w_off_wt     = w_sum < {1'b0, LEAVE_WT};
  assign w_diff_small = {1'b0, w_diff} < {2'b00, w_sum[12:2]};

  // diff > floor(15*sum/16) is exactly 16*diff > 15*sum for integer diff;
  // the scaled form keeps every product bit in use.
  assign w_diff_x16 = {1'b0, w_diff, 4'b0000};
  assign w_sum_x15  = {4'b0000, w_sum} * 17'd15;
  assign w_diff_big = w_diff_x16 > w_sum_x15;

  // --------------------------------------------------------------------------
  // Settle timer
  // --------------------------------------------------------------------------
  steer_tmr #(
    .WIDTH (TMR_W)
  ) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_tmr_clr),
    .inc  (w_tmr_inc),
    .full (w_tmr_full)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and timer control; every entry into WAIT clears the timer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_tmr_clr = 1'b0;
    w_tmr_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_on_wt) begin
          w_next    = WAIT;
          w_tmr_clr = 1'b1;
        end
      end
      WAIT: begin
        if (w_off_wt) begin
          w_next = IDLE;
        end else if (!w_diff_small) begin
          w_tmr_clr = 1'b1;
        end else if (w_tmr_full) begin
          w_next = STEER;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      STEER: begin
        if (w_off_wt) begin
          w_next = IDLE;
        end else if (w_diff_big) begin
          w_next    = WAIT;
          w_tmr_clr = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    en_steer  = (r_state == STEER);
    rider_off = (r_state == IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_steer_en.sv
`default_nettype none
// ============================================================================
// Module  : tb_steer_en
// Purpose : Self-checking bench for steer_en (FAST_SIM=1). A cycle model
//           predicts outputs and timer each clock; predictions are queued
//           when stimulus is applied and compared after the edge. Scenario
//           tasks add explicit latency and boundary checks.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_steer_en;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft;
  logic [11:0] rght;
  logic        en_steer;
  logic        rider_off;

  typedef struct packed {
    logic        en;
    logic        roff;
    logic [14:0] tmr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_state = 0;   // 0 IDLE, 1 WAIT, 2 STEER
  int   m_tmr   = 0;

  steer_en #(
    .FAST_SIM (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_ld    (lft),
    .rght_ld   (rght),
    .en_steer  (en_steer),
    .rider_off (rider_off)
  );

  always #5 clk = ~clk;

  // Reference behaviour for one clock edge using the current inputs.
  task automatic model_step();
    int s, d;
    bit on_wt, off_wt, ds, db;
    s      = int'(lft) + int'(rght);
    d      = (lft > rght) ? int'(lft) - int'(rght) : int'(rght) - int'(lft);
    on_wt  = s > 512;
    off_wt = s < 448;
    ds     = d < (s >> 2);
    db     = d > ((s * 15) >> 4);
    if (rst) begin
      m_state = 0;
      m_tmr   = 0;
    end else begin
      case (m_state)
        0: if (on_wt) begin m_state = 1; m_tmr = 0; end
        1: begin
          if (off_wt)              m_state = 0;
          else if (!ds)            m_tmr = 0;
          else if (m_tmr == 32767) m_state = 2;
          else                     m_tmr = m_tmr + 1;
        end
        default: begin
          if (off_wt)  m_state = 0;
          else if (db) begin m_state = 1; m_tmr = 0; end
        end
      endcase
    end
  endtask

  // Push prediction, clock once, pop and compare.
  task automatic tick();
    exp_t e;
    exp_t a;
    model_step();
    sb.push_back('{en: (m_state == 2), roff: (m_state == 0), tmr: m_tmr[14:0]});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    a = '{en: en_steer, roff: rider_off, tmr: dut.u_tmr.r_count};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_model t=%0t en/roff/tmr actual %b/%b/%0d required %b/%b/%0d",
               $time, a.en, a.roff, a.tmr, e.en, e.roff, e.tmr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; lft = 12'h000; rght = 12'h000;
    repeat (3) tick();
    checks++;
    if ({en_steer, rider_off, dut.u_tmr.r_count} !== {1'b0, 1'b1, 15'd0}) begin
      errors++;
      $display("FAIL reset_state en/roff/tmr actual %b/%b/%0d required 0/1/0",
               en_steer, rider_off, dut.u_tmr.r_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_threshold();
    lft = 12'h100; rght = 12'h100;
    repeat (2000) tick();
    checks++;
    if (rider_off !== 1'b1) begin
      errors++;
      $display("FAIL sum_at_threshold rider_off actual %b required 1", rider_off);
    end
  endtask

  // Count edges until en_steer rises; returns -1 on timeout.
  task automatic wait_steer(output int n);
    n = -1;
    for (int i = 1; i <= 40000; i++) begin
      tick();
      if (en_steer === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_mount_balanced();
    int n;
    lft = 12'h180; rght = 12'h180;
    tick();
    checks++;
    if ({en_steer, rider_off} !== 2'b00) begin
      errors++;
      $display("FAIL mount_wait en/roff actual %b/%b required 0/0", en_steer, rider_off);
    end
    wait_steer(n);
    checks++;
    if (n != 32768) begin
      errors++;
      $display("FAIL mount_latency clocks actual %0d required 32768", n);
    end
  endtask

  task automatic test_leave();
    lft = 12'h0E0; rght = 12'h0E0;
    repeat (20) tick();
    checks++;
    if (en_steer !== 1'b1) begin
      errors++;
      $display("FAIL hysteresis_hold en_steer actual %b required 1", en_steer);
    end
    lft = 12'h0D0; rght = 12'h0D0;
    tick();
    checks++;
    if ({en_steer, rider_off} !== 2'b01) begin
      errors++;
      $display("FAIL leave_idle en/roff actual %b/%b required 0/1", en_steer, rider_off);
    end
  endtask

  task automatic test_imbalance_wait();
    int n;
    lft = 12'h300; rght = 12'h080;
    repeat (1000) tick();
    checks++;
    if ({en_steer, rider_off, dut.u_tmr.r_count} !== {1'b0, 1'b0, 15'd0}) begin
      errors++;
      $display("FAIL imbalance_hold en/roff/tmr actual %b/%b/%0d required 0/0/0",
               en_steer, rider_off, dut.u_tmr.r_count);
    end
    lft = 12'h1C0; rght = 12'h1C0;
    wait_steer(n);
    checks++;
    if (n != 32768) begin
      errors++;
      $display("FAIL balance_latency clocks actual %0d required 32768", n);
    end
  endtask

  task automatic test_step_off();
    lft = 12'h3F0; rght = 12'h000;
    tick();
    checks++;
    if ({en_steer, rider_off, dut.u_tmr.r_count} !== {1'b0, 1'b0, 15'd0}) begin
      errors++;
      $display("FAIL step_off en/roff/tmr actual %b/%b/%0d required 0/0/0",
               en_steer, rider_off, dut.u_tmr.r_count);
    end
  endtask

  task automatic test_reset_mid();
    lft = 12'h1C0; rght = 12'h1C0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({en_steer, rider_off, dut.u_tmr.r_count} !== {1'b0, 1'b1, 15'd0}) begin
      errors++;
      $display("FAIL reset_mid en/roff/tmr actual %b/%b/%0d required 0/1/0",
               en_steer, rider_off, dut.u_tmr.r_count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rider_off !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_after_reset rider_off actual %b required 0", rider_off);
    end
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_mount_balanced();
    test_leave();
    test_imbalance_wait();
    test_step_off();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
